servo_pwm_player: RTL and testbench
===================================

// Module: servo_pwm_player
// PURPOSE
//  Consumer end of the duty-cycle recorder/playback memory. Converts the played-back 6-bit
//  duty words DC_X/DC_Y into two servo PWM waveforms (fixed frame, pulse = MIN + duty*STEP).
//  Duty words are sampled only at frame boundaries. A one-cycle Sample_Req per frame lets the
//  playback side advance its read address in step with the servo frames.
// PARAMETERS
//  TICK_DIV   50     sysclk cycles per timing tick (1 us at 50 MHz)
//  PERIOD_US  20000  frame length in ticks
//  MIN_US     1000   pulse width in ticks for duty 0
//  STEP_US    16     extra ticks per duty LSB (duty 63 -> 2008 ticks)
//  DW         6      duty word width
// PORTS
//  sysclk      in   1   system clock, all logic on posedge
//  Reset_n     in   1   asynchronous active-low reset
//  Enable      in   1   level; 1 = generate frames, 0 = idle
//  DC_X        in   DW  X-axis duty word from playback memory
//  DC_Y        in   DW  Y-axis duty word from playback memory
//  PWM_X       out  1   X servo PWM, registered
//  PWM_Y       out  1   Y servo PWM, registered
//  Sample_Req  out  1   one-cycle pulse: duty words were latched, upstream may advance
//  Active      out  1   1 while frames are being generated
// BEHAVIOUR
//  - Reset (async, Reset_n=0): prescaler, tick counter, shadow duties, widths, PWM_X, PWM_Y,
//    Sample_Req, Active all 0. Reset mid-pulse drops PWM immediately.
//  - Prescaler counts 0..TICK_DIV-1 while Active; tick = prescaler==TICK_DIV-1.
//  - Tick counter tcnt counts 0..PERIOD_US-1 on tick, wraps to 0.
//  - Frame boundary FB = (Enable & ~Active) | (Active & tick & tcnt==PERIOD_US-1).
//  - On FB: shadow_x<=DC_X, shadow_y<=DC_Y; wid_x<=MIN_US+DC_X*STEP_US (same for y);
//    tcnt<=0, prescaler<=0, Active<=1. Widths 16-bit unsigned, no overflow by construction.
//  - Sample_Req=1 for exactly the cycle after each FB, else 0.
//  - PWM_X<=Active & Enable & (tcnt<wid_x), computed from post-FB state; PWM rises the cycle
//    after FB, high exactly wid_x*TICK_DIV cycles; frame exactly PERIOD_US*TICK_DIV cycles.
//  - DC_X/DC_Y changes between boundaries are ignored (shadowed); glitch-free widths.
//  - Enable=0: next edge Active<=0, PWM_X/PWM_Y<=0, counters cleared, no Sample_Req.
//    Enable re-asserted: FB on first cycle seen high -> fresh frame from tcnt=0.
//  - Enable=1 during FB and Enable=0 in same cycle: Enable=0 wins (no latch, no Sample_Req).
//  - Duty 0 still yields MIN_US pulse (servo never receives a zero-width pulse).
//  - Elaboration check: MIN_US+((1<<DW)-1)*STEP_US < PERIOD_US, else $error.
// STRUCTURE
//  - Package servo_pkg: default TICK_DIV/PERIOD_US/MIN_US/STEP_US constants, duty_t typedef
//    (logic [DW-1:0]), function pulse_ticks(duty) shared with any future servo blocks.
//  - One sub-module: tick_prescaler (counter with clear+enable, outputs tick pulse).
//  - Two identical channel comparators inline (generate or two assigns), no FSM beyond
//    Active idle/run bit.
// TESTING  (sim params: TICK_DIV=2, PERIOD_US=100, MIN_US=10, STEP_US=1 -> frame 200 cycles)
//  1. DC_X=0, DC_Y=63, Enable=1 -> PWM_X high 20 cycles, PWM_Y high 146 cycles, period 200.
//  2. Continuous run 3 frames -> Sample_Req one cycle wide, exactly every 200 cycles, first 1
//     cycle after Enable rise.
//  3. DC_X 5->40 at cycle 50 of frame -> current frame PWM_X stays 30 cycles; next frame 100.
//  4. Enable dropped mid-pulse -> PWM_X/Y low next edge, Active=0, no Sample_Req; re-enable ->
//     Sample_Req 1 cycle later, new frame from tcnt=0.
//  5. Reset_n low mid-pulse (not on clock edge) -> all outputs 0 without waiting for sysclk.
//  6. DC_X=63 with PERIOD_US=60 -> elaboration $error fires.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing constants, duty-word type and pulse-width helper.
package servo_pkg;

  localparam int unsigned TICK_DIV_DEF  = 50;     // sysclk cycles per 1 us tick at 50 MHz
  localparam int unsigned PERIOD_US_DEF = 20000;  // 20 ms servo frame
  localparam int unsigned MIN_US_DEF    = 1000;   // pulse for duty 0
  localparam int unsigned STEP_US_DEF   = 16;     // extra ticks per duty LSB
  localparam int unsigned DW_DEF        = 6;      // duty word width

  // Tick counter and pulse widths share one 16-bit unsigned domain.
  localparam int unsigned TW = 16;

  typedef logic [DW_DEF-1:0] duty_t;
  typedef logic [TW-1:0]     ticks_t;

  // Pulse width in ticks for a duty word; duty 0 still gives min_us.
  function automatic ticks_t pulse_ticks(input logic [TW-1:0] duty,
                                         input int unsigned   min_us  = MIN_US_DEF,
                                         input int unsigned   step_us = STEP_US_DEF);
    int unsigned t;
    t = min_us + 32'(duty) * step_us;
    return ticks_t'(t);
  endfunction

endpackage

// File: rtl/servo_pwm_player_tick_prescaler.sv
// Divides sysclk down to a one-cycle timing tick; clear wins over enable.
module tick_prescaler #(
  parameter int unsigned DIV = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == PW'(DIV - 1));

  // Next count: clear, wrap on tick, otherwise step while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_pwm_player.sv
// Two-channel servo PWM generator fed by a playback memory. Duty words are
// shadowed at frame boundaries and a one-cycle Sample_Req tells upstream to
// advance to the next word.
module servo_pwm_player
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned PERIOD_US = PERIOD_US_DEF,
  parameter int unsigned MIN_US    = MIN_US_DEF,
  parameter int unsigned STEP_US   = STEP_US_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          sysclk,
  input  logic          Reset_n,
  input  logic          Enable,
  input  logic [DW-1:0] DC_X,
  input  logic [DW-1:0] DC_Y,
  output logic          PWM_X,
  output logic          PWM_Y,
  output logic          Sample_Req,
  output logic          Active
);

  localparam int unsigned NCH = 2;

  // The widest pulse has to end inside the frame or the servo never sees a low phase.
  if (MIN_US + ((1 << DW) - 1) * STEP_US >= PERIOD_US) begin : g_width_chk
    $error("servo_pwm_player: MIN_US + max duty * STEP_US must be below PERIOD_US");
  end

  logic                     active_q, active_d;
  logic                     sreq_q;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  logic [NCH-1:0][DW-1:0]   dc;
  logic [NCH-1:0][DW-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0][TW-1:0]   wid_q, wid_d;
  logic [NCH-1:0]           pwm_q, pwm_d;
  logic                     tick, last_tick, fb;

  assign dc = {DC_Y, DC_X};

  // Prescaler runs only while frames are generated; every boundary or
  // disable restarts it so each frame begins on a whole tick.
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk_i  (sysclk),
    .rst_ni (Reset_n),
    .clr_i  (fb | ~Enable),
    .en_i   (active_q),
    .tick_o (tick)
  );

  assign last_tick = tick & (tcnt_q == TW'(PERIOD_US - 1));
  // Boundary: first enabled cycle out of idle, or end of the running frame.
  // Gating with Enable lets a same-cycle disable win.
  assign fb = Enable & (~active_q | last_tick);

  // Frame state, duty shadows and per-channel compare.
  always_comb begin
    active_d = active_q;
    tcnt_d   = tcnt_q;
    shadow_d = shadow_q;
    wid_d    = wid_q;
    pwm_d    = '0;
    if (!Enable) begin
      active_d = 1'b0;
      tcnt_d   = '0;
    end else if (fb) begin
      active_d = 1'b1;
      tcnt_d   = '0;
      shadow_d = dc;
    end else if (tick) begin
      tcnt_d   = tcnt_q + 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      wid_d[c] = pulse_ticks(TW'(shadow_d[c]), MIN_US, STEP_US);
      // Fresh width only on the boundary cycle; otherwise the registered
      // width keeps the multiplier off the compare path.
      pwm_d[c] = Enable & active_d & (tcnt_d < (fb ? wid_d[c] : wid_q[c]));
    end
  end

  // State registers; reset drops the PWM outputs immediately.
  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_q <= 1'b0;
      sreq_q   <= 1'b0;
      tcnt_q   <= '0;
      shadow_q <= '0;
      wid_q    <= '0;
      pwm_q    <= '0;
    end else begin
      active_q <= active_d;
      sreq_q   <= fb;
      tcnt_q   <= tcnt_d;
      shadow_q <= shadow_d;
      wid_q    <= wid_d;
      pwm_q    <= pwm_d;
    end
  end

  assign PWM_X      = pwm_q[0];
  assign PWM_Y      = pwm_q[1];
  assign Sample_Req = sreq_q;
  assign Active     = active_q;

endmodule

// File: tb/tb_servo_pwm_player.sv
// Randomized bench: a frame-level model predicts each frame's start, length
// and high time per channel; a monitor measures the DUT's frames and compares.
module tb_servo_pwm_player;

  localparam int TD   = 2;
  localparam int PER  = 100;
  localparam int MINW = 10;
  localparam int STEP = 1;
  localparam int DW   = 6;
  localparam int FRAME = TD * PER;

  logic          sysclk = 1'b0;
  logic          Reset_n;
  logic          Enable;
  logic [DW-1:0] DC_X, DC_Y;
  logic          PWM_X, PWM_Y, Sample_Req, Active;

  servo_pwm_player #(
    .TICK_DIV  (TD),
    .PERIOD_US (PER),
    .MIN_US    (MINW),
    .STEP_US   (STEP),
    .DW        (DW)
  ) dut (
    .sysclk     (sysclk),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .DC_X       (DC_X),
    .DC_Y       (DC_Y),
    .PWM_X      (PWM_X),
    .PWM_Y      (PWM_Y),
    .Sample_Req (Sample_Req),
    .Active     (Active)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int start;
    int len;
    int hx;
    int hy;
  } frame_t;

  frame_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: frames restart whenever enabled out of idle or after a
  // full FRAME cycles; the pulse is (MIN + duty*STEP) ticks, cut short if the
  // frame is aborted by Enable going low.
  bit m_run = 0;
  int m_start, m_len, m_wx, m_wy;
  always @(posedge sysclk) begin
    cyc = cyc + 1;
    if (Reset_n !== 1'b1) begin
      m_run = 0;
    end else begin
      if (m_run && (!Enable || m_len == FRAME)) begin
        exp_q.push_back('{m_start, m_len, imin(m_wx, m_len), imin(m_wy, m_len)});
        m_run = 0;
      end
      if (Enable && !m_run) begin
        m_run   = 1;
        m_start = cyc;
        m_len   = 0;
        m_wx    = TD * (MINW + STEP * int'(DC_X));
        m_wy    = TD * (MINW + STEP * int'(DC_Y));
      end
      if (m_run) m_len = m_len + 1;
    end
  end

  // Monitor: a frame opens on Sample_Req and closes on the next Sample_Req
  // or when Active drops; its measurements are checked against the model.
  bit     in_fr = 0;
  bit     act_prev = 0;
  int     f_start, f_len, f_hx, f_hy;
  frame_t e;
  always @(negedge sysclk) begin
    if (Reset_n !== 1'b1) begin
      in_fr = 0;
    end else begin
      if (in_fr && (Sample_Req || !Active)) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_start", f_start, e.start);
          check("frame_len",   f_len,   e.len);
          check("pwm_x_high",  f_hx,    e.hx);
          check("pwm_y_high",  f_hy,    e.hy);
        end
        in_fr = 0;
      end
      if (act_prev && !Active) begin
        check("idle_pwm_x", int'(PWM_X), 0);
        check("idle_pwm_y", int'(PWM_Y), 0);
        check("idle_sreq",  int'(Sample_Req), 0);
      end
      if (Sample_Req) begin
        check("sreq_active", int'(Active), 1);
        check("pwm_x_rise",  int'(PWM_X), 1);
        in_fr   = 1;
        f_start = cyc;
        f_len   = 0;
        f_hx    = 0;
        f_hy    = 0;
      end
      if (in_fr) begin
        f_len = f_len + 1;
        f_hx  = f_hx + int'(PWM_X);
        f_hy  = f_hy + int'(PWM_Y);
      end
    end
    act_prev = Active;
  end

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    Reset_n = 1'b1;
    Enable  = 1'b0;
    DC_X    = '0;
    DC_Y    = '0;
    #1 Reset_n = 1'b0;
    step(3);
    check("rst_pwm_x", int'(PWM_X), 0);
    check("rst_pwm_y", int'(PWM_Y), 0);
    check("rst_sreq",  int'(Sample_Req), 0);
    check("rst_active", int'(Active), 0);
    Reset_n = 1'b1;
    step(2);

    // Extreme duties over three full frames.
    DC_X = 6'd0;
    DC_Y = 6'd63;
    Enable = 1'b1;
    step(1);
    check("first_sreq", int'(Sample_Req), 1);
    step(599);

    // Mid-frame duty change must only take effect on the next frame.
    DC_X = 6'd5;
    step(51);
    DC_X = 6'd40;
    step(360);

    // Disable mid-pulse, then re-enable.
    Enable = 1'b0;
    step(1);
    check("dis_pwm_x",  int'(PWM_X), 0);
    check("dis_active", int'(Active), 0);
    check("dis_sreq",   int'(Sample_Req), 0);
    step(4);
    Enable = 1'b1;
    step(1);
    check("reen_sreq", int'(Sample_Req), 1);
    step(250);

    // Asynchronous reset in the middle of a pulse.
    seen = 0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      step(1);
      if (Sample_Req) seen = 1;
    end
    check("sreq_before_reset", int'(seen), 1);
    @(posedge sysclk);
    @(posedge sysclk);
    #2;
    check("pre_reset_pwm_x", int'(PWM_X), 1);
    Reset_n = 1'b0;
    #1;
    check("async_pwm_x",  int'(PWM_X), 0);
    check("async_pwm_y",  int'(PWM_Y), 0);
    check("async_sreq",   int'(Sample_Req), 0);
    check("async_active", int'(Active), 0);
    step(2);
    Reset_n = 1'b1;
    step(1);

    // Random duties and Enable glitches.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        Enable = 1'b0;
        step($urandom_range(1, 20));
        Enable = 1'b1;
      end else begin
        DC_X = DW'($urandom_range(0, 63));
        DC_Y = DW'($urandom_range(0, 63));
      end
      step($urandom_range(1, 400));
    end

    Enable = 1'b0;
    step(5);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
